lsu: RTL and testbench

- Load/store unit sitting directly downstream of the ALU.
- Consumes the ALU's effective address (mem_addr) and rs2 store data, and runs a single request/acknowledge transaction on the data-memory bus.
- For loads, returns the lane-aligned, sign- or zero-extended word that the ALU's mem_data input consumes.
- Asserts busy so the control path stalls until the access completes.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_align.sv | 66 ++++++
 rtl/lsu.sv | 138 +++++++++++++
 tb/tb_lsu.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned STRB_W          = XLEN / 8;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // funct3 width/sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the LSU (combinational).
//   funct3, off, is_store : access shape and direction
//   store_data            : rs2 value, replicated onto the lanes as wdata
//   wstrb                 : byte enables for a store of this shape
//   rdata / load_val      : raw bus word in, extended load result out
//   err                   : misaligned access or illegal funct3/direction
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic              is_store,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic [XLEN-1:0]   load_val,
  output logic              err
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Halfword lane uses off[1] only; off[0]=1 is flagged as misaligned.
  assign lane_b = rdata[{off, 3'b000} +: 8];
  assign lane_h = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    wdata    = store_data;
    wstrb    = 4'b1111;
    load_val = rdata;
    err      = 1'b0;
    case (funct3)
      F3_B: begin
        wdata    = {4{store_data[7:0]}};
        wstrb    = 4'b0001 << off;
        load_val = {{24{lane_b[7]}}, lane_b};
      end
      F3_BU: begin
        wdata    = {4{store_data[7:0]}};
        wstrb    = 4'b0001 << off;
        load_val = {24'h0, lane_b};
        err      = is_store;
      end
      F3_H: begin
        wdata    = {2{store_data[15:0]}};
        wstrb    = 4'b0011 << off;
        load_val = {{16{lane_h[15]}}, lane_h};
        err      = off[0];
      end
      F3_HU: begin
        wdata    = {2{store_data[15:0]}};
        wstrb    = 4'b0011 << off;
        load_val = {16'h0, lane_h};
        err      = off[0] | is_store;
      end
      F3_W: begin
        err = (off != 2'b00);
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: runs one req/ack data-memory transaction per issue.
//   start/is_load/is_store/funct3/mem_addr/store_data : issue from control/ALU
//   busy/done/fault/load_data                         : status and load result
//   bus_req/bus_we/bus_addr/bus_wdata/bus_wstrb       : registered memory request
//   bus_ack/bus_rdata                                 : memory response
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   store_data,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [XLEN-1:0]   load_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [STRB_W-1:0] bus_wstrb,
  input  logic              bus_ack,
  input  logic [XLEN-1:0]   bus_rdata
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              r_load;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;

  logic              sel_issue;
  logic              issue;
  logic [2:0]        a_f3;
  logic [1:0]        a_off;
  logic              a_store;
  logic [XLEN-1:0]   a_wdata;
  logic [STRB_W-1:0] a_wstrb;
  logic [XLEN-1:0]   a_load;
  logic              a_err;

  // One aligner: fed live issue inputs in IDLE, latched shape while waiting for ack.
  assign sel_issue = (state == IDLE);
  assign issue     = sel_issue & start & (is_load | is_store);
  assign a_f3      = sel_issue ? funct3 : r_f3;
  assign a_off     = sel_issue ? mem_addr[1:0] : r_off;
  assign a_store   = sel_issue ? ~is_load : ~r_load;

  lsu_align u_align (
    .funct3     (a_f3),
    .off        (a_off),
    .is_store   (a_store),
    .store_data (store_data),
    .rdata      (bus_rdata),
    .wdata      (a_wdata),
    .wstrb      (a_wstrb),
    .load_val   (a_load),
    .err        (a_err)
  );

  // Transaction FSM, timeout counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      r_load    <= 1'b0;
      r_f3      <= 3'b000;
      r_off     <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      load_data <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            busy      <= 1'b1;
            cnt       <= '0;
            r_load    <= is_load;
            r_f3      <= funct3;
            r_off     <= mem_addr[1:0];
            bus_we    <= ~is_load;
            bus_addr  <= {mem_addr[XLEN-1:2], 2'b00};
            bus_wdata <= a_wdata;
            bus_wstrb <= is_load ? '0 : a_wstrb;
            if (a_err) begin
              state <= RESP;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              state   <= REQ;
              bus_req <= 1'b1;
            end
          end
        end
        REQ: begin
          // An ack on the final allowed cycle still completes normally.
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= RESP;
            done    <= 1'b1;
            if (r_load) load_data <= a_load;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            bus_req <= 1'b0;
            state   <= RESP;
            done    <= 1'b1;
            fault   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomized, self-checking bench for lsu against a behavioural access model.
module tb_lsu;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] mem_addr, store_data;
  logic        busy, done, fault;
  logic [31:0] load_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int vecs = 0;
  int errs = 0;
  logic [31:0] exp_load = 32'h0;

  lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .mem_addr(mem_addr), .store_data(store_data),
    .busy(busy), .done(done), .fault(fault), .load_data(load_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model ----
  function automatic bit m_err(input logic [2:0] f3, input logic [1:0] off, input bit st);
    case (f3)
      3'b000: return 1'b0;
      3'b001: return off[0];
      3'b010: return off != 2'b00;
      3'b100: return st;
      3'b101: return st || off[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] rd);
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (rd >> (8 * int'(off))) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'd128) v = v + 32'hFFFFFF00;
      end
      3'b001, 3'b101: begin
        v = (rd >> (8 * int'(off))) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3)
      3'b000:  return (sd & 32'hFF) * 32'h01010101;
      3'b001:  return (sd & 32'hFFFF) * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  return 4'(1 << off);
      3'b001:  return 4'(3 << off);
      default: return 4'hF;
    endcase
  endfunction

  // Issue one access and follow it to completion. waits = idle cycles before ack;
  // waits+1 > TO means the memory never answers.
  task automatic run_access(input bit ld, input bit st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input logic [31:0] rd, input int waits, input string nm);
    bit is_st, err, to;
    int ack_c;
    start = 1'b1; is_load = ld; is_store = st; funct3 = f3; mem_addr = addr; store_data = sd;
    tick();
    start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'($urandom); mem_addr = $urandom; store_data = $urandom;
    if (!ld && !st) begin
      vecs++;
      if ({busy, bus_req, done} !== 3'b000) begin
        errs++; $display("FAIL %s ignored_start: busy/req/done=%b need 000", nm, {busy, bus_req, done});
      end
      return;
    end
    is_st = !ld;
    err = m_err(f3, addr[1:0], is_st);
    if (err) begin
      vecs++;
      if ({bus_req, done, fault, busy} !== 4'b0111) begin
        errs++; $display("FAIL %s issue_fault: req/done/fault/busy=%b need 0111", nm, {bus_req, done, fault, busy});
      end
    end else begin
      to = (waits + 1 > int'(TO));
      ack_c = waits + 1;
      for (int c = 1; c <= int'(TO); c++) begin
        vecs++;
        if ({bus_req, busy, done} !== 3'b110 || bus_addr !== {addr[31:2], 2'b00} || bus_we !== is_st) begin
          errs++;
          $display("FAIL %s req_c%0d: req/busy/done=%b we=%b addr=%h need 110 we=%b addr=%h",
                   nm, c, {bus_req, busy, done}, bus_we, bus_addr, is_st, {addr[31:2], 2'b00});
        end
        vecs++;
        if (is_st ? (bus_wdata !== m_wdata(f3, sd) || bus_wstrb !== m_wstrb(f3, addr[1:0]))
                  : (bus_wstrb !== 4'h0)) begin
          errs++;
          $display("FAIL %s lanes_c%0d: wdata=%h wstrb=%b need wdata=%h wstrb=%b", nm, c,
                   bus_wdata, bus_wstrb, m_wdata(f3, sd), is_st ? m_wstrb(f3, addr[1:0]) : 4'h0);
        end
        if (!to && c == ack_c) begin bus_ack = 1'b1; bus_rdata = rd; end
        else bus_rdata = $urandom;
        tick();
        bus_ack = 1'b0;
        if (!to && c == ack_c) break;
      end
      if (!to && ld) exp_load = m_load(f3, addr[1:0], rd);
      vecs++;
      if ({bus_req, done, fault, busy} !== {3'b010 | {2'b00, to}, 1'b1}) begin
        errs++; $display("FAIL %s done: req/done/fault/busy=%b need %b", nm,
                         {bus_req, done, fault, busy}, {1'b0, 1'b1, to, 1'b1});
      end
    end
    vecs++;
    if (load_data !== exp_load) begin
      errs++; $display("FAIL %s load_data: got %h need %h", nm, load_data, exp_load);
    end
    tick();
    vecs++;
    if ({done, busy, bus_req} !== 3'b000) begin
      errs++; $display("FAIL %s idle_after: done/busy/req=%b need 000", nm, {done, busy, bus_req});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; is_load = 0; is_store = 0; funct3 = 0; mem_addr = 0;
    store_data = 0; bus_ack = 0; bus_rdata = 0;
    tick(); tick();
    vecs++;
    if ({busy, done, fault, bus_req, bus_we} !== 5'b0 || load_data !== 32'h0 ||
        bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_wstrb !== 4'h0) begin
      errs++; $display("FAIL reset_outputs: ctl=%b ld=%h addr=%h wd=%h strb=%b need all zero",
                       {busy, done, fault, bus_req, bus_we}, load_data, bus_addr, bus_wdata, bus_wstrb);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_access(1, 0, 3'b000, 32'h1003, 32'h0, 32'h80112233, 0, "lb");
    vecs++;
    if (load_data !== 32'hFFFFFF80) begin
      errs++; $display("FAIL lb_value: got %h need FFFFFF80", load_data);
    end
    run_access(1, 0, 3'b101, 32'h1002, 32'h0, 32'hBEEF1234, 3, "lhu");
    vecs++;
    if (load_data !== 32'h0000BEEF) begin
      errs++; $display("FAIL lhu_value: got %h need 0000BEEF", load_data);
    end
    run_access(0, 1, 3'b000, 32'h2001, 32'h123456AB, 32'hDEADBEEF, 1, "sb");
    run_access(0, 1, 3'b001, 32'h2002, 32'hCAFE5678, 32'h0, 0, "sh");
    run_access(0, 1, 3'b010, 32'h2004, 32'h89ABCDEF, 32'h0, 2, "sw");
    run_access(1, 1, 3'b010, 32'h2008, 32'h0, 32'h13572468, 0, "both_is_load");
  endtask

  task automatic test_fault();
    // Misaligned LW with a second start held into cycle 1.
    start = 1; is_load = 1; is_store = 0; funct3 = 3'b010; mem_addr = 32'h1002;
    tick();
    mem_addr = 32'h1000;
    vecs++;
    if ({bus_req, done, fault, busy} !== 4'b0111) begin
      errs++; $display("FAIL lw_misalign: req/done/fault/busy=%b need 0111", {bus_req, done, fault, busy});
    end
    tick();
    start = 0; is_load = 0;
    vecs++;
    if ({bus_req, busy, done} !== 3'b000) begin
      errs++; $display("FAIL second_start_ignored: req/busy/done=%b need 000", {bus_req, busy, done});
    end
    run_access(1, 0, 3'b011, 32'h1000, 32'h0, 32'h0, 0, "f3_011");
    run_access(0, 1, 3'b100, 32'h1000, 32'h0, 32'h0, 0, "store_bu");
    run_access(1, 0, 3'b001, 32'h1001, 32'h0, 32'h0, 0, "lh_odd");
    run_access(0, 0, 3'b010, 32'h1000, 32'h0, 32'h0, 0, "no_dir");
  endtask

  task automatic test_timeout();
    run_access(1, 0, 3'b010, 32'h3000, 32'h0, 32'h0, 100, "timeout");
    run_access(1, 0, 3'b010, 32'h3004, 32'h0, 32'h0F0F0F0F, int'(TO) - 1, "ack_last_cycle");
  endtask

  task automatic test_reset_mid();
    start = 1; is_load = 0; is_store = 1; funct3 = 3'b010; mem_addr = 32'h4000; store_data = 32'h55AA55AA;
    tick();
    start = 0; is_store = 0;
    tick();
    rst = 1'b1;
    #1;
    vecs++;
    if ({bus_req, busy, done} !== 3'b000) begin
      errs++; $display("FAIL reset_mid: req/busy/done=%b need 000", {bus_req, busy, done});
    end
    tick();
    rst = 1'b0;
    exp_load = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (done !== 1'b0) begin
        errs++; $display("FAIL reset_no_done: done=%b need 0", done);
      end
    end
    run_access(1, 0, 3'b010, 32'h4000, 32'h0, 32'hA5A5F00D, 1, "after_reset_lw");
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      bit ld, st;
      logic [2:0] f3;
      logic [31:0] a;
      ld = 1'($urandom);
      st = ($urandom_range(0, 7) != 0) ? !ld : 1'($urandom);
      f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5));
      if (f3 == 3'b011) f3 = 3'b100;
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (f3 == 3'b010) ? 2'b00 : {a[1], 1'b0};
      run_access(ld, st, f3, a, $urandom, $urandom, $urandom_range(0, 5), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_fault();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
